// File: rtl/render_pkg.sv
// Constants and types shared by the render pipeline (coordinate distributor,
// iteration engines, pixel collector).
package render_pkg;

    localparam int unsigned NUM_ENGINES      = 12;
    localparam int unsigned ITER_WIDTH       = 8;
    localparam int unsigned PIXEL_DATA_WIDTH = 10;

    typedef logic [ITER_WIDTH-1:0]       iter_t;
    typedef logic [PIXEL_DATA_WIDTH-1:0] coord_t;

    localparam coord_t SCREEN_WIDTH  = 10'd640;
    localparam coord_t SCREEN_HEIGHT = 10'd480;

    typedef enum logic {
        StIdle,
        StDrain
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter: steps one pixel per advance, wrapping at the
// end of each line and frame, and decodes start-of-frame / end-of-line.
module raster_counter
    import render_pkg::*;
#(
    parameter coord_t WIDTH  = SCREEN_WIDTH,
    parameter coord_t HEIGHT = SCREEN_HEIGHT
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic sof,
    output logic eol
);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (x_q == WIDTH - 1'b1) begin
                x_d = '0;
                y_d = (y_q == HEIGHT - 1'b1) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign sof = (x_q == '0) && (y_q == '0);
    assign eol = (x_q == WIDTH - 1'b1);

endmodule

// File: rtl/pixel_collector.sv
// Collects one iteration count per engine into a capture buffer, hands full batches
// to an output buffer, and streams them in raster order with sof/eol markers.
module pixel_collector #(
    parameter int unsigned         NUM_ENGINES   = render_pkg::NUM_ENGINES,
    parameter int unsigned         ITER_WIDTH    = render_pkg::ITER_WIDTH,
    parameter render_pkg::coord_t  SCREEN_WIDTH  = render_pkg::SCREEN_WIDTH,
    parameter render_pkg::coord_t  SCREEN_HEIGHT = render_pkg::SCREEN_HEIGHT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENGINES-1:0] eng_done,
    input  logic [ITER_WIDTH-1:0]  eng_iter [NUM_ENGINES],
    output logic                   fin_flag,
    output logic [ITER_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   overrun
);

    localparam int unsigned IDX_W = $clog2(NUM_ENGINES);

    logic [NUM_ENGINES-1:0] mask_q, mask_d;
    logic [ITER_WIDTH-1:0]  cap_buf_q [NUM_ENGINES];
    logic [ITER_WIDTH-1:0]  out_buf_q [NUM_ENGINES];
    render_pkg::state_t     state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, idx_inc;
    logic [ITER_WIDTH-1:0]  data_q, beat_data;
    logic                   fin_q, sof_q, eol_q, overrun_q;
    logic                   mask_full, hs, last_beat, transfer, load_beat;
    logic                   pos_sof, pos_eol;

    assign mask_full = &mask_q;
    assign hs        = (state_q == render_pkg::StDrain) && out_ready;
    assign last_beat = (idx_q == IDX_W'(NUM_ENGINES - 1));
    assign idx_inc   = idx_q + 1'b1;
    // A full batch moves over when the stream is idle or on the final handshake,
    // so back-to-back batches stream without a bubble.
    assign transfer  = mask_full && ((state_q == render_pkg::StIdle) || (hs && last_beat));
    assign load_beat = transfer || (hs && !last_beat);

    always_comb begin
        mask_d    = mask_q | eng_done;
        state_d   = state_q;
        idx_d     = idx_q;
        beat_data = '0;
        if (transfer) begin
            mask_d    = '0;
            state_d   = render_pkg::StDrain;
            idx_d     = '0;
            beat_data = cap_buf_q[0];
        end else if (hs) begin
            if (last_beat) begin
                state_d = render_pkg::StIdle;
            end else begin
                idx_d     = idx_inc;
                beat_data = out_buf_q[idx_inc];
            end
        end
    end

    // The counter tracks the position of the next beat to be loaded.
    raster_counter #(
        .WIDTH  (SCREEN_WIDTH),
        .HEIGHT (SCREEN_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .advance (load_beat),
        .sof     (pos_sof),
        .eol     (pos_eol)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= render_pkg::StIdle;
            mask_q    <= '0;
            idx_q     <= '0;
            fin_q     <= 1'b0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            fin_q     <= transfer;
            overrun_q <= overrun_q | (|(eng_done & mask_q));
            if (load_beat) begin
                data_q <= beat_data;
                sof_q  <= pos_sof;
                eol_q  <= pos_eol;
            end
        end
    end

    // Buffer contents are only meaningful under the mask, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (eng_done[i] && !mask_q[i]) begin
                cap_buf_q[i] <= eng_iter[i];
            end
        end
        if (transfer) begin
            out_buf_q <= cap_buf_q;
        end
    end

    assign fin_flag  = fin_q;
    assign out_data  = data_q;
    assign out_valid = (state_q == render_pkg::StDrain);
    assign out_sof   = sof_q;
    assign out_eol   = eol_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_collector.sv
// Scoreboard bench for pixel_collector: stimulus pushes expected beats, a monitor
// pops and compares on every handshake. Frame height is shortened to 3 lines.
module tb_pixel_collector;

    localparam int NE = 12;
    localparam int W  = 640;
    localparam int H  = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NE-1:0] eng_done = '0;
    logic [7:0]    eng_iter [NE];
    logic          fin_flag, out_valid, out_sof, out_eol, overrun;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;

    beat_t      exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         fin_cnt = 0;
    int         beat_no = 0;
    int         px = 0;
    int         py = 0;
    logic [7:0] batch_data [NE];
    int         ord [NE] = '{7, 2, 11, 0, 5, 9, 1, 3, 10, 4, 8, 6};

    logic       stall_q = 1'b0;
    beat_t      hold_q;

    pixel_collector #(
        .SCREEN_HEIGHT (10'd3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .eng_done  (eng_done),
        .eng_iter  (eng_iter),
        .fin_flag  (fin_flag),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: scoreboard pop on handshake, plus hold-stability while stalled.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp_b;
        got = {out_data, out_sof, out_eol};
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (fin_flag) fin_cnt++;
            if (stall_q) begin
                checks++;
                if (!out_valid || got != hold_q) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b beat=%0h required valid=1 beat=%0h",
                             out_valid, got, hold_q);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat%0d: got unexpected data=%0h sof=%0b eol=%0b",
                             beat_no, out_data, out_sof, out_eol);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got != exp_b) begin
                        failures++;
                        $display("FAIL beat%0d: got data=%0h sof=%0b eol=%0b required data=%0h sof=%0b eol=%0b",
                                 beat_no, out_data, out_sof, out_eol, exp_b.data, exp_b.sof, exp_b.eol);
                    end
                end
                beat_no++;
            end
            stall_q = out_valid && !out_ready;
            hold_q  = got;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_batch();
        beat_t b;
        for (int i = 0; i < NE; i++) begin
            b.data = batch_data[i];
            b.sof  = (px == 0 && py == 0);
            b.eol  = (px == W - 1);
            exp_q.push_back(b);
            if (px == W - 1) begin
                px = 0;
                py = (py == H - 1) ? 0 : py + 1;
            end else begin
                px++;
            end
        end
    endtask

    task automatic pulse_all();
        eng_done = '1;
        for (int i = 0; i < NE; i++) eng_iter[i] = batch_data[i];
        tick();
        eng_done = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, int'(n < 500), 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int vcnt;
        for (int i = 0; i < NE; i++) eng_iter[i] = '0;

        // Reset values
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_fin", fin_flag, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_eol", out_eol, 0);
        chk("rst_data", out_data, 0);
        chk("rst_overrun", overrun, 0);

        // T1: all engines at once, data = engine index
        for (int i = 0; i < NE; i++) batch_data[i] = 8'(i);
        push_batch();
        pulse_all();
        chk("t1_fin_early", fin_flag, 0);
        tick();
        chk("t1_fin", fin_flag, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_sof", out_sof, 1);
        tick();
        chk("t1_fin_once", fin_flag, 0);
        wait_idle("t1_drain");
        chk("t1_fin_cnt", fin_cnt, 1);

        // T2: staggered arrival, output in engine order
        base = fin_cnt;
        for (int i = 0; i < NE; i++) batch_data[i] = 8'hA0 + 8'(i);
        push_batch();
        for (int k = 0; k < NE; k++) begin
            if (k == NE - 1) begin
                chk("t2_no_fin", fin_cnt, base);
                chk("t2_no_valid", out_valid, 0);
            end
            eng_done = '0;
            eng_done[ord[k]] = 1'b1;
            eng_iter[ord[k]] = batch_data[ord[k]];
            tick();
            eng_done = '0;
            tick();
        end
        wait_idle("t2_drain");
        chk("t2_fin_cnt", fin_cnt, base + 1);

        // T3: back-pressure withholds the second transfer
        base = fin_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < NE; i++) batch_data[i] = 8'h40 + 8'(i);
        push_batch();
        pulse_all();
        tick();
        tick();
        chk("t3_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < NE; i++) batch_data[i] = 8'hC0 + 8'(i);
        push_batch();
        pulse_all();
        repeat (6) tick();
        chk("t3_fin_withheld", fin_cnt, base + 1);
        chk("t3_hold_data", out_data, 8'h41);
        out_ready = 1'b1;
        vcnt = 0;
        repeat (23) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("t3_no_bubble", vcnt, 23);
        tick();
        wait_idle("t3_drain");
        chk("t3_fin_cnt", fin_cnt, base + 2);
        chk("t3_overrun", overrun, 0);

        // T4: long run across line ends and the frame wrap
        base = fin_cnt;
        for (int b = 0; b < 157; b++) begin
            for (int i = 0; i < NE; i++) batch_data[i] = 8'((b * 7 + i) & 255);
            push_batch();
            pulse_all();
            repeat (11) tick();
        end
        wait_idle("t4_drain");
        chk("t4_fin_cnt", fin_cnt, base + 157);

        // T5: duplicate done on engine 5
        for (int i = 0; i < NE; i++) batch_data[i] = 8'h30 + 8'(i);
        batch_data[5] = 8'h55;
        push_batch();
        eng_done = '0;
        eng_done[5] = 1'b1;
        eng_iter[5] = 8'h55;
        tick();
        chk("t5_ovr_first", overrun, 0);
        eng_iter[5] = 8'hEE;
        tick();
        eng_done = '0;
        chk("t5_ovr_set", overrun, 1);
        for (int i = 0; i < NE; i++) eng_iter[i] = batch_data[i];
        eng_done = '1;
        eng_done[5] = 1'b0;
        tick();
        eng_done = '0;
        wait_idle("t5_drain");
        chk("t5_ovr_sticky", overrun, 1);

        // T6: reset during beat 6 of a drain
        for (int i = 0; i < NE; i++) batch_data[i] = 8'h60 + 8'(i);
        push_batch();
        pulse_all();
        n = 0;
        while (exp_q.size() != 6 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_reach_beat6", int'(n < 40), 1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("t6_valid", out_valid, 0);
        chk("t6_fin", fin_flag, 0);
        chk("t6_overrun", overrun, 0);
        px = 0;
        py = 0;
        for (int i = 0; i < NE; i++) batch_data[i] = 8'h70 + 8'(i);
        push_batch();
        pulse_all();
        tick();
        chk("t6_sof", out_sof, 1);
        wait_idle("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_collector.md
Name: pixel_collector

Overview:
- Downstream of the coordinate distributor and the NUM_ENGINES parallel iteration engines.
- Gathers one iteration-count result per engine for the current batch into a capture buffer.
- When every engine has reported, moves the batch to an output buffer and pulses fin_flag to the distributor so it advances to the next batch.
- Serialises the batch in raster order onto a valid/ready pixel stream with start-of-frame and end-of-line markers for the video/DMA sink.

Parameters:
NUM_ENGINES, 12, engines per batch; must match the distributor
ITER_WIDTH, 8, width of each engine's iteration count
SCREEN_WIDTH, 10'd640, pixels per line
SCREEN_HEIGHT, 10'd480, lines per frame
PIXEL_DATA_WIDTH, 10, width of the internal x/y pixel counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
eng_done  input  NUM_ENGINES  per-engine one-cycle pulse: result valid on eng_iter[i]
eng_iter  input  NUM_ENGINES x ITER_WIDTH (unpacked array)  per-engine iteration count
fin_flag  output  1  one-cycle pulse: batch captured, distributor advances
out_data  output  ITER_WIDTH  pixel iteration count
out_valid  output  1  out_data/out_sof/out_eol valid
out_ready  input  1  sink accepts the current beat
out_sof  output  1  beat is pixel (0,0)
out_eol  output  1  beat is the last pixel of a line (x = SCREEN_WIDTH-1)
overrun  output  1  sticky error: eng_done for an engine already captured in this batch

Behaviour:
- Clocking and reset: one clock domain, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: fin_flag=0, out_valid=0, out_sof=0, out_eol=0, out_data=0, overrun=0. Done mask cleared, drain index=0, x_cnt=y_cnt=0.
- Reset mid-batch or mid-drain discards all buffered data. The first beat after reset is pixel (0,0), with out_sof=1.
- Capture:
  - eng_done[i]=1 with mask[i]=0: cap_buf[i] <= eng_iter[i], mask[i] <= 1.
  - eng_done[i]=1 with mask[i]=1: capture ignored, overrun <= 1 (cleared only by reset).
- mask_full = all NUM_ENGINES mask bits set.
- Transfer condition, evaluated each edge: mask_full && (out_busy==0 || the final beat of the current drain handshakes this cycle).
- On transfer:
  - out_buf <= cap_buf, mask <= 0, drain index <= 0, out_busy <= 1.
  - fin_flag=1 for exactly that following cycle.
  - out_valid=1 in the same cycle as fin_flag. Latency from the last done pulse to fin_flag/first valid beat is 1 cycle.
- Back-pressure: if mask_full but out_busy (not on its last beat), the transfer and fin_flag are withheld. The distributor therefore stalls; there is no data loss.
- Done pulses in the transfer cycle are treated per the full mask and flag overrun.
- States:
  - IDLE (out_busy=0): transfer → DRAIN.
  - DRAIN: beat k = out_buf[k].
  - On handshake (out_valid && out_ready): k increments and x/y advance.
  - At k=NUM_ENGINES-1 with handshake: transfer if its condition holds (out_valid stays 1, no bubble), else → IDLE with out_valid=0.
- Stream rules:
  - out_valid stays high until the handshake; out_data/out_sof/out_eol are stable while out_valid && !out_ready.
- Raster counters:
  - x_cnt wraps SCREEN_WIDTH-1 → 0 and increments y_cnt.
  - y_cnt wraps SCREEN_HEIGHT-1 → 0.
  - out_sof = (x_cnt==0 && y_cnt==0).
  - out_eol = (x_cnt==SCREEN_WIDTH-1).
  - Batches may straddle lines, since SCREEN_WIDTH need not be a multiple of NUM_ENGINES.
- Widths: counter compares are done at PIXEL_DATA_WIDTH; out_data passes ITER_WIDTH through with no truncation.

Decomposition:
- Shared package (render_pkg): NUM_ENGINES, SCREEN_WIDTH, SCREEN_HEIGHT, PIXEL_DATA_WIDTH, ITER_WIDTH defaults; typedef iter_t (logic [ITER_WIDTH-1:0]); typedef coord_t (logic [PIXEL_DATA_WIDTH-1:0]); enum state_t {IDLE, DRAIN}. The distributor uses the same constants.
- One sub-module, raster_counter: x/y counters with advance input, wrap, sof and eol outputs. It is reusable by the distributor.

Test Plan:
1. Reset, then all 12 engines pulse done in the same cycle with iter=i → fin_flag high exactly 1 cycle later for 1 cycle; beats 0..11 carry data 0..11, first beat out_sof=1, out_ready=1 gives 12 consecutive beats.
2. Done pulses staggered over 20 cycles in random engine order → fin_flag only after the 12th pulse; output order is by engine index, not arrival order.
3. out_ready held low after the first beat while a second batch completes → fin_flag withheld and data stable; releasing out_ready drains the remaining 11 beats, then the second batch follows with no bubble and exactly one fin_flag.
4. Run 54 batches (648 pixels) → out_eol on pixel 639 (batch 53, beat 3); the next beat is x=0,y=1; after 25600 batches, out_sof reasserts on pixel (0,0).
5. Engine 5 pulses done twice before the batch completes → overrun=1 and stays 1; cap_buf[5] keeps the first value.
6. Assert reset during beat 6 of a drain → next cycle out_valid=0, fin_flag=0, overrun=0; the next completed batch starts with out_sof=1.
